wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of write-back data.
REQ-002 Parameter NUM_REGISTERS, default 16: register count; REG_ADDR_BITS = ceil(log2(NUM_REGISTERS)).
REQ-003 Port clk  input  1: clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: reset, synchronous, active-high.
REQ-005 Ports alu_valid / alu_ready  input / output  1 / 1: ALU write-back handshake.
REQ-006 Ports alu_addr / alu_data  input  REG_ADDR_BITS / DATA_WIDTH: ALU destination and value.
REQ-007 Ports mem_valid / mem_ready  input / output  1 / 1: load write-back handshake.
REQ-008 Ports mem_addr / mem_data  input  REG_ADDR_BITS / DATA_WIDTH: load destination and value.
REQ-009 Ports rf_write_enable / rf_write_addr / rf_write_data  output  1 / REG_ADDR_BITS / DATA_WIDTH: register-file write port drive.
REQ-010 Port busy_mask  output  NUM_REGISTERS: bit i set while a write to register i is pending.
REQ-011 Port stall_count  output  16: saturating count of cycles a requester is refused.

Function
REQ-012 Each requester SHALL own a one-entry holding buffer (valid, addr, data, age).
REQ-013 A transfer SHALL occur when valid and ready are both high on a rising edge; the transferred entry lands in that requester's buffer.
REQ-014 xxx_ready SHALL be high when its buffer is empty or is granted in the same cycle (same-cycle drain and refill).
REQ-015 Each cycle the arbiter SHALL grant at most one full buffer; the grant loads the output register and empties the buffer.
REQ-016 When both buffers are full, the older entry SHALL win; on equal age, the requester not granted last SHALL win (round-robin via last_grant bit).
REQ-017 Age: an entry loaded while the other buffer is already full SHALL be younger; entries loaded on the same edge SHALL be equal.
REQ-018 rf_write_enable/addr/data SHALL be registered; uncontended latency from accepting transfer to rf_write_enable high is 2 cycles.
REQ-019 rf_write_enable SHALL be high for exactly one cycle per accepted transfer; no transfer is dropped or duplicated.
REQ-020 Writes to the same address SHALL reach the port in acceptance order.
REQ-021 rf_write_addr/data SHALL hold their last values when rf_write_enable is low.
REQ-022 busy_mask SHALL be the OR of one-hot decodes of every full buffer address and the output register address while rf_write_enable is high.
REQ-023 stall_count SHALL increment by 1 per cycle in which at least one xxx_valid is high with its xxx_ready low, saturating at 16'hFFFF.
REQ-024 No address is reserved; address 0 is written like any other.

Reset
REQ-025 While reset is high at an edge: both buffers empty, ages cleared, last_grant = ALU, rf_write_enable = 0, rf_write_addr = 0, rf_write_data = 0, busy_mask = 0, stall_count = 0.
REQ-026 Reset mid-operation SHALL discard buffered entries and any write registered that edge; reset overrides handshakes.
REQ-027 alu_ready and mem_ready SHALL be high in the first cycle after reset deasserts.

Structure
REQ-028 REG_ADDR_BITS derivation, the requester enumeration (ALU = 0, MEM = 1) and the stall_count width SHALL live in the shared core package.
REQ-029 One sub-module, wb_hold_buffer, SHALL implement the per-requester holding buffer and be instantiated twice.
REQ-030 Implementation SHALL be single-clock and free of latches.

Verification
REQ-031 ALU alone sends addr 3, data 0xDEADBEEF at cycle 0 -> rf_write_enable at cycle 2 with addr 3, data 0xDEADBEEF; busy_mask = 0x0008 in cycles 1-2.
REQ-032 ALU (addr 1, 0x11) and MEM (addr 2, 0x22) accepted on the same edge -> ALU written first, MEM one cycle later; next tie grants MEM first.
REQ-033 MEM (addr 5, 0xAA) accepted while ALU buffer holds a stalled entry, then ALU (addr 5, 0xBB) -> older entry written first; register 5 final value equals the later-accepted data.
REQ-034 Both valid continuously for 10 cycles -> writes alternate ALU/MEM, one per cycle, none lost; stall_count increments on each refused cycle.
REQ-035 Reset asserted with both buffers full -> next cycle busy_mask = 0, rf_write_enable = 0, stall_count = 0, both ready high; no stale write appears afterwards.
REQ-036 Force 70000 refused cycles -> stall_count saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared definitions for the write-back arbiter: requester
//               enumeration, stall counter width, address width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

  localparam int STALL_COUNT_WIDTH = 16;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } requester_e;

  // Register-address width for a given register count (never narrower than 1).
  function automatic int reg_addr_bits(input int num_registers);
    return (num_registers > 1) ? $clog2(num_registers) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_hold_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_hold_buffer
// Description : One-entry holding buffer for a write-back requester. Accepts
//               a new entry when empty or when drained in the same cycle, and
//               tracks a relative age bit against the other requester.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hold_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [ADDR_BITS-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  grant,
  input  logic                  other_loading,
  output logic                  ready,
  output logic                  loading,
  output logic                  full,
  output logic [ADDR_BITS-1:0]  addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  age
);

  // Ready when empty or being drained this cycle, so drain and refill overlap.
  assign ready   = !full || grant;
  assign loading = valid && ready;

  // Entry storage; age=1 marks an entry that was already waiting when the
  // other requester loaded, i.e. this entry is the older of the two.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      age  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (loading) begin
      full <= 1'b1;
      age  <= 1'b0;
      addr <= in_addr;
      data <= in_data;
    end else if (grant) begin
      full <= 1'b0;
      age  <= 1'b0;
    end else if (full && other_loading) begin
      age  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Arbitrates ALU and load write-backs onto a single registered
//               register-file write port. Oldest entry wins; ties alternate
//               via last_grant. Reports pending destinations and stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     alu_valid,
  output logic                                     alu_ready,
  input  logic [reg_addr_bits(NUM_REGISTERS)-1:0]  alu_addr,
  input  logic [DATA_WIDTH-1:0]                    alu_data,
  input  logic                                     mem_valid,
  output logic                                     mem_ready,
  input  logic [reg_addr_bits(NUM_REGISTERS)-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]                    mem_data,
  output logic                                     rf_write_enable,
  output logic [reg_addr_bits(NUM_REGISTERS)-1:0]  rf_write_addr,
  output logic [DATA_WIDTH-1:0]                    rf_write_data,
  output logic [NUM_REGISTERS-1:0]                 busy_mask,
  output logic [STALL_COUNT_WIDTH-1:0]             stall_count
);

  localparam int REG_ADDR_BITS = reg_addr_bits(NUM_REGISTERS);

  logic                     alu_full, mem_full;
  logic                     alu_age, mem_age;
  logic                     alu_loading, mem_loading;
  logic                     grant_alu, grant_mem;
  logic [REG_ADDR_BITS-1:0] alu_buf_addr, mem_buf_addr;
  logic [DATA_WIDTH-1:0]    alu_buf_data, mem_buf_data;
  logic                     stall_event;
  requester_e               last_grant;

  wb_hold_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (REG_ADDR_BITS)
  ) u_alu_buf (
    .clk           (clk),
    .reset         (reset),
    .valid         (alu_valid),
    .in_addr       (alu_addr),
    .in_data       (alu_data),
    .grant         (grant_alu),
    .other_loading (mem_loading),
    .ready         (alu_ready),
    .loading       (alu_loading),
    .full          (alu_full),
    .addr          (alu_buf_addr),
    .data          (alu_buf_data),
    .age           (alu_age)
  );

  wb_hold_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (REG_ADDR_BITS)
  ) u_mem_buf (
    .clk           (clk),
    .reset         (reset),
    .valid         (mem_valid),
    .in_addr       (mem_addr),
    .in_data       (mem_data),
    .grant         (grant_mem),
    .other_loading (alu_loading),
    .ready         (mem_ready),
    .loading       (mem_loading),
    .full          (mem_full),
    .addr          (mem_buf_addr),
    .data          (mem_buf_data),
    .age           (mem_age)
  );

  // Grant selection: a lone full buffer wins; when both are full the older
  // wins, and equal ages go to the requester that lost the last contest.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_full && mem_full) begin
      if (alu_age != mem_age) begin
        grant_alu = alu_age;
        grant_mem = mem_age;
      end else if (last_grant == REQ_ALU) begin
        grant_mem = 1'b1;
      end else begin
        grant_alu = 1'b1;
      end
    end else begin
      grant_alu = alu_full;
      grant_mem = mem_full;
    end
  end

  // last_grant records the winner of the most recent contested decision;
  // uncontested drains leave the round-robin pointer untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_ALU;
    end else if (alu_full && mem_full) begin
      last_grant <= grant_mem ? REQ_MEM : REQ_ALU;
    end
  end

  // Registered write port; address and data hold while enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else if (grant_alu) begin
      rf_write_enable <= 1'b1;
      rf_write_addr   <= alu_buf_addr;
      rf_write_data   <= alu_buf_data;
    end else if (grant_mem) begin
      rf_write_enable <= 1'b1;
      rf_write_addr   <= mem_buf_addr;
      rf_write_data   <= mem_buf_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  // Pending-write scoreboard: every buffered destination plus the one in flight.
  always_comb begin
    busy_mask = '0;
    if (alu_full) busy_mask[alu_buf_addr] = 1'b1;
    if (mem_full) busy_mask[mem_buf_addr] = 1'b1;
    if (rf_write_enable) busy_mask[rf_write_addr] = 1'b1;
  end

  assign stall_event = (alu_valid && !alu_ready) || (mem_valid && !mem_ready);

  // Saturating count of cycles in which some requester was refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_event && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed bench for wb_arbiter with a write-port scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0, mem_addr = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready;
  logic          rf_write_enable;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic [15:0]   busy_mask;
  logic [15:0]   stall_count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] shadow [16];
  bit            sb_enable = 1'b1;
  int            total = 0;
  int            bad = 0;

  wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGISTERS(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .busy_mask       (busy_mask),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  // Monitor: every write-port pulse is matched against the next expected write.
  always @(negedge clk) begin
    if (sb_enable && rf_write_enable) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 rf_write_addr, rf_write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_write_addr !== e.addr || rf_write_data !== e.data) begin
          bad++;
          $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_write_addr, rf_write_data, e.addr, e.data);
        end
      end
      shadow[rf_write_addr] = rf_write_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One-cycle offer on either or both requesters; readiness is required.
  task automatic send(input logic a, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic m, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    alu_valid = a; alu_addr = aa; alu_data = ad;
    mem_valid = m; mem_addr = ma; mem_data = md;
    if (a) check("alu_ready_on_send", {31'b0, alu_ready}, 32'd1);
    if (m) check("mem_ready_on_send", {31'b0, mem_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int ak;
    int mk;
    bit a_fire;
    bit m_fire;

    // Reset state and first cycle after deassertion
    do_reset();
    check("rst_we", {31'b0, rf_write_enable}, 32'd0);
    check("rst_addr", {28'b0, rf_write_addr}, 32'd0);
    check("rst_data", rf_write_data, 32'd0);
    check("rst_busy", {16'b0, busy_mask}, 32'd0);
    check("rst_stall", {16'b0, stall_count}, 32'd0);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd1);

    // Single ALU write: two-cycle latency, busy bit across the pipeline
    expect_wr(4'd3, 32'hDEADBEEF);
    send(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    check("lat_c1_busy", {16'b0, busy_mask}, 32'h0008);
    check("lat_c1_we", {31'b0, rf_write_enable}, 32'd0);
    step();
    check("lat_c2_busy", {16'b0, busy_mask}, 32'h0008);
    check("lat_c2_we", {31'b0, rf_write_enable}, 32'd1);
    check("lat_c2_addr", {28'b0, rf_write_addr}, 32'd3);
    check("lat_c2_data", rf_write_data, 32'hDEADBEEF);
    step();
    check("lat_c3_we", {31'b0, rf_write_enable}, 32'd0);
    check("lat_c3_busy", {16'b0, busy_mask}, 32'd0);
    check("hold_addr", {28'b0, rf_write_addr}, 32'd3);
    check("hold_data", rf_write_data, 32'hDEADBEEF);
    drain("drain_single");

    // Three ties in a row: MEM, then ALU, then MEM wins the tie
    do_reset();
    expect_wr(4'd7, 32'h77);
    expect_wr(4'd6, 32'h66);
    send(1'b1, 4'd6, 32'h66, 1'b1, 4'd7, 32'h77);
    step();
    step();
    expect_wr(4'd1, 32'h11);
    expect_wr(4'd2, 32'h22);
    send(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    step();
    check("tie_first_addr", {28'b0, rf_write_addr}, 32'd1);
    check("tie_first_data", rf_write_data, 32'h11);
    step();
    check("tie_second_addr", {28'b0, rf_write_addr}, 32'd2);
    check("tie_second_we", {31'b0, rf_write_enable}, 32'd1);
    expect_wr(4'd13, 32'hD1);
    expect_wr(4'd12, 32'hC1);
    send(1'b1, 4'd12, 32'hC1, 1'b1, 4'd13, 32'hD1);
    step();
    check("tie_next_addr", {28'b0, rf_write_addr}, 32'd13);
    step();
    check("tie_next2_addr", {28'b0, rf_write_addr}, 32'd12);
    drain("drain_ties");

    // Age ordering on a shared destination
    do_reset();
    expect_wr(4'd9, 32'h99);
    expect_wr(4'd4, 32'h44);
    expect_wr(4'd5, 32'hAA);
    expect_wr(4'd5, 32'hBB);
    send(1'b1, 4'd4, 32'h44, 1'b1, 4'd9, 32'h99);
    send(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hAA);
    send(1'b1, 4'd5, 32'hBB, 1'b0, 4'd0, 32'd0);
    drain("drain_age");
    check("reg5_final", shadow[5], 32'hBB);

    // Both requesters offering continuously for 10 cycles
    do_reset();
    for (int k = 0; k < 5; k++) begin
      expect_wr(AW'(8 + k), 32'hB000_0000 + k);
      expect_wr(AW'(k), 32'hA000_0000 + k);
    end
    expect_wr(4'd13, 32'hB000_0005);
    ak = 0;
    mk = 0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1'b1; alu_addr = AW'(ak); alu_data = 32'hA000_0000 + ak;
      mem_valid = 1'b1; mem_addr = AW'(8 + mk); mem_data = 32'hB000_0000 + mk;
      a_fire = alu_ready;
      m_fire = mem_ready;
      step();
      if (a_fire) ak++;
      if (m_fire) mk++;
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("stream_alu_accepted", ak, 32'd5);
    check("stream_mem_accepted", mk, 32'd6);
    drain("drain_stream");
    check("stream_stalls", {16'b0, stall_count}, 32'd9);

    // Reset with both buffers full discards everything
    send(1'b1, 4'd14, 32'hE0, 1'b1, 4'd15, 32'hF0);
    check("prereset_busy", {16'b0, busy_mask}, 32'hC000);
    reset = 1'b1;
    step();
    check("midrst_busy", {16'b0, busy_mask}, 32'd0);
    check("midrst_we", {31'b0, rf_write_enable}, 32'd0);
    check("midrst_stall", {16'b0, stall_count}, 32'd0);
    check("midrst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("midrst_mem_ready", {31'b0, mem_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("postrst_busy", {16'b0, busy_mask}, 32'd0);

    // Stall counter saturation over 70000 cycles of contention
    do_reset();
    sb_enable = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h2;
    for (int i = 0; i < 65535; i++) step();
    check("stall_pre_sat", {16'b0, stall_count}, 32'hFFFE);
    step();
    check("stall_sat", {16'b0, stall_count}, 32'hFFFF);
    for (int i = 0; i < 4464; i++) step();
    check("stall_no_wrap", {16'b0, stall_count}, 32'hFFFF);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    sb_enable = 1'b1;
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
